// File: rtl/rr_mux_nx1_pkg.sv
// Shared definitions for the round-robin mux and its matching demux.
// Lane-index width helper, parameter range limits and output-register state encoding.
package rr_mux_nx1_pkg;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;
  localparam int unsigned W_MIN = 1;

  // EMPTY/FULL is exactly the out_valid bit
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mux_state_e;

  // ceil(log2(n)) with a floor of 1 so a lane index is never zero-width
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N.
module rr_arbiter
  import rr_mux_nx1_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          any
);

  localparam int unsigned SW1 = SW + 1;

  // One extra bit holds ptr+k (at most 2N-2) before the wrap at N
  always_comb begin
    logic [SW1-1:0] sum;
    logic [SW-1:0]  lane;
    sum       = '0;
    lane      = '0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = SW1'(ptr) + SW1'(k);
      if (sum >= SW1'(N)) sum = sum - SW1'(N);
      lane = SW'(sum);
      if (!any && req[lane]) begin
        any       = 1'b1;
        grant_idx = lane;
      end
    end
    if (en && any) grant = N'(1) << grant_idx;
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// Round-robin N-to-1 valid/ready stream mux with a registered output lane.
// Each held beat carries its source lane index on out_sel.
module rr_mux_nx1
  import rr_mux_nx1_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = idx_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  mux_state_e    state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load_en_c;
  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          any;
  logic [W-1:0]  lane_data [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane_data[i] = in_data[i*W +: W];
  end

  // Register is free when empty or being drained this cycle
  assign load_en_c = (state_q == ST_EMPTY) || out_ready;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .en        (load_en_c),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign in_ready  = grant;
  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  // Load granted lane, or go empty when nothing is offered; pointer wraps at N
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load_en_c) begin
      if (any) begin
        state_d = ST_FULL;
        data_d  = lane_data[grant_idx];
        sel_d   = grant_idx;
        ptr_d   = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Self-checking bench for rr_mux_nx1: an N=4 and an N=3 instance against a queue-free
// behavioural model, plus directed literal expectations.
module tb_rr_mux_nx1;

  logic        clk;
  logic        rst;

  logic [3:0]  v4;
  logic [31:0] d4;
  logic        r4;
  logic [3:0]  rdy4;
  logic        ov4;
  logic [7:0]  od4;
  logic [1:0]  os4;

  logic [2:0]  v3;
  logic [23:0] d3;
  logic        r3;
  logic [2:0]  rdy3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  os3;

  int checks   = 0;
  int failures = 0;

  rr_mux_nx1 #(.N(4), .W(8)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(r4)
  );

  rr_mux_nx1 #(.N(3), .W(8)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(r3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state, index 0 = N=4 instance, 1 = N=3 instance
  int         m_ptr  [2] = '{0, 0};
  logic       m_val  [2] = '{1'b0, 1'b0};
  logic [7:0] m_data [2] = '{8'h00, 8'h00};
  int         m_sel  [2] = '{0, 0};

  function automatic int pick(input int n, input int p, input logic [15:0] v);
    for (int k = 0; k < n; k++) begin
      int l;
      l = (p + k) % n;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_ready(input int i, input int n, input logic [15:0] v,
                                            input logic r);
    int g;
    if (m_val[i] && !r) return 32'd0;
    g = pick(n, m_ptr[i], v);
    if (g < 0) return 32'd0;
    return 32'd1 << g;
  endfunction

  task automatic model_step(input int i, input int n, input logic [15:0] v,
                            input logic [127:0] d, input logic r);
    int g;
    if (!m_val[i] || r) begin
      g = pick(n, m_ptr[i], v);
      if (g >= 0) begin
        m_val[i]  = 1'b1;
        m_data[i] = d[g*8 +: 8];
        m_sel[i]  = g;
        m_ptr[i]  = (g + 1) % n;
      end else begin
        m_val[i] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_val[i] = 1'b0; m_data[i] = 8'h00; m_sel[i] = 0; m_ptr[i] = 0;
      end
    end else begin
      model_step(0, 4, 16'(v4), 128'(d4), r4);
      model_step(1, 3, 16'(v3), 128'(d3), r3);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model
  always @(negedge clk) begin
    chk("m4_valid", 32'(ov4),  32'(m_val[0]));
    chk("m4_data",  32'(od4),  32'(m_data[0]));
    chk("m4_sel",   32'(os4),  32'(m_sel[0]));
    chk("m4_ready", 32'(rdy4), exp_ready(0, 4, 16'(v4), r4));
    chk("m3_valid", 32'(ov3),  32'(m_val[1]));
    chk("m3_data",  32'(od3),  32'(m_data[1]));
    chk("m3_sel",   32'(os3),  32'(m_sel[1]));
    chk("m3_ready", 32'(rdy3), exp_ready(1, 3, 16'(v3), r3));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit4(input string nm, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({nm, "_valid"}, 32'(ov4), 32'(v));
    chk({nm, "_data"},  32'(od4), 32'(d));
    chk({nm, "_sel"},   32'(os4), 32'(s));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v4 = '0; d4 = '0; r4 = 1'b1;
    v3 = '0; d3 = '0; r3 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    lit4("reset", 1'b0, 8'h00, 2'd0);
    chk("reset_ready", 32'(rdy4), 32'h0);

    // Round robin, all lanes valid
    tick();
    v4 = 4'hF; d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(negedge clk);
    chk("rr_ready0", 32'(rdy4), 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) begin
        v4 = 4'b0010; d4 = {8'hA3, 8'hA2, 8'h55, 8'hA0};
      end
      @(negedge clk);
      lit4("rr", 1'b1, 8'hA0 + 8'(i % 4), 2'(i % 4));
    end

    // Backpressure on a held 0x55 beat
    tick();
    r4 = 1'b0; v4 = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      lit4("bp_hold", 1'b1, 8'h55, 2'd1);
      chk("bp_ready", 32'(rdy4), 32'h0);
    end
    tick();
    r4 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(rdy4), 32'h4);
    tick();
    v4 = 4'b0010; d4 = {8'hA3, 8'hA2, 8'h3C, 8'hA0};
    @(negedge clk);
    lit4("bp_next", 1'b1, 8'hA2, 2'd2);

    // Sparse single beat then idle
    tick();
    v4 = 4'b0000;
    @(negedge clk);
    lit4("sparse", 1'b1, 8'h3C, 2'd1);
    tick();
    @(negedge clk);
    lit4("idle0", 1'b0, 8'h3C, 2'd1);
    tick();
    @(negedge clk);
    lit4("idle1", 1'b0, 8'h3C, 2'd1);

    // Fairness: lanes 0 and 3; pointer sits at 2 so lane 3 leads
    tick();
    v4 = 4'b1001; d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      if (i % 2 == 0) lit4("fair", 1'b1, 8'hA3, 2'd3);
      else            lit4("fair", 1'b1, 8'hA0, 2'd0);
    end

    // Asynchronous reset while holding a beat
    tick();
    r4 = 1'b0;
    @(negedge clk);
    lit4("pre_rst", 1'b1, 8'hA3, 2'd3);
    #1 rst = 1'b1;
    #1;
    lit4("async_rst", 1'b0, 8'h00, 2'd0);
    tick();
    tick();
    rst = 1'b0; v4 = 4'b0101; r4 = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy4), 32'h1);
    tick();
    @(negedge clk);
    lit4("post_rst0", 1'b1, 8'hA0, 2'd0);
    tick();
    v4 = 4'b0000;
    @(negedge clk);
    lit4("post_rst2", 1'b1, 8'hA2, 2'd2);

    // N=3 wrap: lane 2 then back to lane 0
    tick();
    v3 = 3'b100; d3 = {8'hC2, 8'hC1, 8'hC0};
    tick();
    v3 = 3'b101;
    @(negedge clk);
    chk("w3_sel2", 32'(os3), 32'd2);
    chk("w3_data2", 32'(od3), 32'hC2);
    chk("w3_ready_wrap", 32'(rdy3), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("w3_alt_sel", 32'(os3), (i % 2 == 0) ? 32'd0 : 32'd2);
      chk("w3_alt_data", 32'(od3), (i % 2 == 0) ? 32'hC0 : 32'hC2);
    end
    v3 = 3'b000;
    tick();
    tick();
    @(negedge clk);
    chk("w3_idle", 32'(ov3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
